// File: rtl/irq_entry_sequencer_pkg.sv
// irq_entry_sequencer_pkg: shared IRQ entry state type and ARM7TDMI CPSR constants
package irq_entry_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, ENTER, FLUSH} irq_seq_state_t;
  localparam logic [4:0] CPSR_MODE_IRQ = 5'b10010;
  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam int CPSR_T = 5;
  localparam logic [31:0] IRQ_VECTOR_ADDR = 32'h0000_0018;
endpackage

// File: rtl/irq_entry_sequencer_if.sv
// irq_entry_sequencer_if: CPU-side bundle between the pipeline and the IRQ entry sequencer
interface irq_entry_sequencer_if #(parameter int CNT_W = 16) ();
  logic nIRQ;
  logic [31:0] cpsr;
  logic instr_boundary;
  logic [31:0] next_pc;
  logic stall;
  logic spsr_we;
  logic [31:0] spsr_wdata;
  logic lr_we;
  logic [31:0] lr_wdata;
  logic cpsr_we;
  logic [31:0] cpsr_wdata;
  logic pc_we;
  logic [31:0] pc_wdata;
  logic flush;
  logic irq_taken;
  logic [CNT_W-1:0] irq_count;
  modport master (
    input nIRQ, cpsr, instr_boundary, next_pc,
    output stall, spsr_we, spsr_wdata, lr_we, lr_wdata, cpsr_we, cpsr_wdata,
    pc_we, pc_wdata, flush, irq_taken, irq_count
  );
  modport slave (
    output nIRQ, cpsr, instr_boundary, next_pc,
    input stall, spsr_we, spsr_wdata, lr_we, lr_wdata, cpsr_we, cpsr_wdata,
    pc_we, pc_wdata, flush, irq_taken, irq_count
  );
endinterface

// File: rtl/irq_entry_counter.sv
// irq_entry_counter: wrapping count of IRQ entries taken
module irq_entry_counter #(parameter int CNT_W = 16) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/irq_entry_sequencer.sv
// irq_entry_sequencer: ARM7TDMI IRQ exception entry (bank CPSR, load LR, switch mode, redirect, flush).
// Define IRQ_ENTRY_COUNT_EN to build the irq_count entry counter.
module irq_entry_sequencer
  import irq_entry_sequencer_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = IRQ_VECTOR_ADDR,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  irq_entry_sequencer_if.master bus
);
  irq_seq_state_t state;
  logic [3:0] flush_cnt;
  logic req;
  always_comb req = ~bus.nIRQ & ~bus.cpsr[CPSR_I] & (bus.cpsr[4:0] != CPSR_MODE_IRQ);
  // Outputs are registered alongside the state so they decode the state they belong to.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      flush_cnt <= '0;
      bus.stall <= 1'b0;
      bus.spsr_we <= 1'b0;
      bus.lr_we <= 1'b0;
      bus.cpsr_we <= 1'b0;
      bus.pc_we <= 1'b0;
      bus.spsr_wdata <= '0;
      bus.lr_wdata <= '0;
      bus.cpsr_wdata <= '0;
      bus.pc_wdata <= '0;
      bus.flush <= 1'b0;
      bus.irq_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= PENDING;
          bus.stall <= 1'b1;
        end
        PENDING: if (!req) begin
          state <= IDLE;
          bus.stall <= 1'b0;
        end else if (bus.instr_boundary) begin
          state <= ENTER;
          bus.spsr_we <= 1'b1;
          bus.lr_we <= 1'b1;
          bus.cpsr_we <= 1'b1;
          bus.pc_we <= 1'b1;
          bus.irq_taken <= 1'b1;
          bus.flush <= 1'b1;
          bus.spsr_wdata <= bus.cpsr;
          bus.lr_wdata <= bus.next_pc + 32'd4;
          bus.cpsr_wdata <= {bus.cpsr[31:8], 1'b1, bus.cpsr[CPSR_F], 1'b0, CPSR_MODE_IRQ};
          bus.pc_wdata <= VECTOR_ADDR;
        end
        ENTER: begin
          state <= FLUSH;
          flush_cnt <= 4'(FLUSH_CYCLES - 1);
          bus.spsr_we <= 1'b0;
          bus.lr_we <= 1'b0;
          bus.cpsr_we <= 1'b0;
          bus.pc_we <= 1'b0;
          bus.irq_taken <= 1'b0;
          bus.spsr_wdata <= '0;
          bus.lr_wdata <= '0;
          bus.cpsr_wdata <= '0;
          bus.pc_wdata <= '0;
        end
        FLUSH: if (flush_cnt == 4'd0) begin
          state <= IDLE;
          bus.stall <= 1'b0;
          bus.flush <= 1'b0;
        end else flush_cnt <= flush_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifdef IRQ_ENTRY_COUNT_EN
  irq_entry_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .inc(state == ENTER),
    .count(bus.irq_count)
  );
`else
  assign bus.irq_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_irq_entry_sequencer.sv
// tb_irq_entry_sequencer: scoreboard bench for IRQ entry; expected writes queued at stimulus, checked on irq_taken.
module tb_irq_entry_sequencer;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 16;
  typedef struct {
    logic [31:0] lr;
    logic [31:0] spsr;
    logic [31:0] cpsr;
    logic [31:0] pc;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  exp_t sb[$];
  irq_entry_sequencer_if #(.CNT_W(CNT_W)) bus ();
  irq_entry_sequencer #(.VECTOR_ADDR(32'h0000_0018), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] irq_cpsr(input logic [31:0] c);
    return (c & 32'hFFFF_FF00) | 32'h80 | (c & 32'h40) | 32'h12;
  endfunction
  function automatic logic [31:0] want_count();
`ifdef IRQ_ENTRY_COUNT_EN
    return 32'(exp_cnt % (1 << CNT_W));
`else
    return 32'd0;
`endif
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_stall"}, 32'(bus.stall), 0);
    check({tag, "_flush"}, 32'(bus.flush), 0);
    check({tag, "_we"}, 32'({bus.spsr_we, bus.lr_we, bus.cpsr_we, bus.pc_we, bus.irq_taken}), 0);
  endtask
  task automatic start_entry(input logic [31:0] c, input logic [31:0] pc);
    bus.cpsr = c;
    bus.next_pc = pc;
    bus.instr_boundary = 1'b1;
    bus.nIRQ = 1'b0;
    sb.push_back('{lr: pc + 32'd4, spsr: c, cpsr: irq_cpsr(c), pc: 32'h18});
    tick();
    check("pend_stall", 32'(bus.stall), 1);
    check("pend_taken", 32'(bus.irq_taken), 0);
    tick();
    check("enter_taken", 32'(bus.irq_taken), 1);
    check("enter_flush", 32'(bus.flush), 1);
    check("enter_stall", 32'(bus.stall), 1);
    bus.nIRQ = 1'b1;
    exp_cnt++;
  endtask
  task automatic do_entry(input logic [31:0] c, input logic [31:0] pc);
    start_entry(c, pc);
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      tick();
      check("flush_on", 32'(bus.flush), 1);
      check("flush_stall", 32'(bus.stall), 1);
      check("flush_taken", 32'(bus.irq_taken), 0);
      check("flush_we", 32'(bus.pc_we), 0);
    end
    tick();
    check_idle("post_flush");
  endtask
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && bus.irq_taken) begin
      if (sb.size() == 0) check("sb_unexpected_entry", 1, 0);
      else begin
        e = sb.pop_front();
        check("lr_wdata", bus.lr_wdata, e.lr);
        check("spsr_wdata", bus.spsr_wdata, e.spsr);
        check("cpsr_wdata", bus.cpsr_wdata, e.cpsr);
        check("pc_wdata", bus.pc_wdata, e.pc);
        check("we_all", 32'({bus.spsr_we, bus.lr_we, bus.cpsr_we, bus.pc_we}), 32'hF);
      end
    end
  end
  initial begin
    bus.nIRQ = 1'b1;
    bus.cpsr = 32'h1F;
    bus.instr_boundary = 1'b0;
    bus.next_pc = 32'h0;
    #12;
    check_idle("reset");
    check("reset_count", 32'(bus.irq_count), 0);
    reset = 1'b0;
    tick();
    check_idle("idle_start");
    do_entry(32'h0000_001F, 32'h0800_0100);
    do_entry(32'h0000_003F, 32'h0800_0222);
    bus.cpsr = 32'h1F;
    bus.instr_boundary = 1'b0;
    bus.nIRQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drop_stall", 32'(bus.stall), 1);
      check("drop_we", 32'({bus.spsr_we, bus.lr_we, bus.cpsr_we, bus.pc_we}), 0);
    end
    bus.nIRQ = 1'b1;
    bus.instr_boundary = 1'b1;
    tick();
    check_idle("drop_idle");
    bus.nIRQ = 1'b0;
    bus.cpsr = 32'h9F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("masked_i");
    end
    bus.cpsr = 32'h12;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("masked_mode");
    end
    bus.nIRQ = 1'b1;
    tick();
    check("count_mid", 32'(bus.irq_count), want_count());
    start_entry(32'h0000_0010, 32'h0300_0040);
    tick();
    check("rst_pre_flush", 32'(bus.flush), 1);
    reset = 1'b1;
    #1;
    check_idle("rst_flush");
    check("rst_count", 32'(bus.irq_count), 0);
    exp_cnt = 0;
    #2;
    reset = 1'b0;
    tick();
    check_idle("rst_after");
    tick();
    check_idle("rst_after2");
    do_entry(32'h0000_001F, 32'hFFFF_FFFE);
    do_entry(32'h6000_0053, 32'h0000_1000);
    do_entry(32'h0000_00D0 & 32'h0000_005F, 32'h0800_0000);
    check("count_3", 32'(bus.irq_count), want_count());
    #20;
    check("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
